// File: rtl/audio_serial_tx.sv
// Sample FIFO plus MSB-first serial shifter driving a 3-wire DAC link.
// Frames run back-to-back while the FIFO holds data; idle otherwise.
module audio_serial_tx #(
  parameter int DATA_W     = 16,
  parameter int FIFO_DEPTH = 4,
  parameter int CLK_DIV    = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [DATA_W-1:0]             sample_in,
  input  logic                          sample_valid,
  output logic                          sck,
  output logic                          ws,
  output logic                          sdo,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          busy,
  output logic                          overflow
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int BW = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  typedef enum logic {
    IDLE,
    SHIFT
  } state_t;

  state_t            state;
  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [DW-1:0]     div;
  logic [BW-1:0]     bit_cnt;
  logic [DATA_W-1:0] shreg;
  logic [DATA_W-1:0] rd_data;
  logic              empty;
  logic              full;
  logic              div_wrap;
  logic              bit_end;
  logic              frame_end;
  logic              pop;
  logic              push;

  assign empty     = (fifo_level == '0);
  assign full      = (fifo_level == LW'(FIFO_DEPTH));
  assign rd_data   = mem[rd_ptr];
  assign div_wrap  = (div == DW'(CLK_DIV - 1));
  assign bit_end   = (state == SHIFT) && sck && div_wrap;
  assign frame_end = bit_end && (bit_cnt == BW'(DATA_W - 1));
  assign pop       = !empty && ((state == IDLE) || frame_end);
  assign push      = sample_valid && (!full || pop);

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= sample_in;
  end

  // a pop in the same cycle frees the slot a full-FIFO write needs
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
      overflow   <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({push, pop})
        2'b10:   fifo_level <= fifo_level + 1'b1;
        2'b01:   fifo_level <= fifo_level - 1'b1;
        default: fifo_level <= fifo_level;
      endcase
      if (sample_valid && full && !pop) overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      sck     <= 1'b0;
      ws      <= 1'b0;
      sdo     <= 1'b0;
      busy    <= 1'b0;
      div     <= '0;
      bit_cnt <= '0;
      shreg   <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          div <= '0;
          sck <= 1'b0;
          ws  <= 1'b0;
          sdo <= 1'b0;
          if (pop) begin
            state   <= SHIFT;
            busy    <= 1'b1;
            shreg   <= rd_data;
            sdo     <= rd_data[DATA_W-1];
            ws      <= 1'b1;
            bit_cnt <= '0;
          end
        end
        SHIFT: begin
          if (div_wrap) begin
            div <= '0;
            sck <= ~sck;
          end else begin
            div <= div + 1'b1;
          end
          // sck falling: end of the current bit period
          if (bit_end) begin
            if (frame_end) begin
              if (pop) begin
                shreg   <= rd_data;
                sdo     <= rd_data[DATA_W-1];
                ws      <= 1'b1;
                bit_cnt <= '0;
              end else begin
                state <= IDLE;
                busy  <= 1'b0;
                sdo   <= 1'b0;
                ws    <= 1'b0;
              end
            end else begin
              shreg   <= {shreg[DATA_W-2:0], 1'b0};
              sdo     <= shreg[DATA_W-2];
              ws      <= 1'b0;
              bit_cnt <= bit_cnt + 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
